// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the lisp memory read arbiter.
// The timeout data word doubles as the core's FETCH_ERROR marker.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  localparam logic [15:0] ARB_TIMEOUT_DATA = 16'hAAAA;

  // (base + off) folded back into 0..n-1; valid for base < n and off < n.
  function automatic int rr_wrap(int base, int off, int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of the memory read arbiter.
// slave = arbiter view; master = the requesters plus the memory they share.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  // req_valid/req_ready: a request is taken on a cycle where both are high for
  // the same index; until then the requester holds req_valid and its address.
  // rsp_valid is a one-cycle pulse with no back-pressure.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_data_ready;
  logic [DATA_W-1:0]         mem_data_out;

  modport slave (
    input  req_valid, req_addr, mem_data_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_data, mem_req, mem_addr
  );

  modport master (
    output req_valid, req_addr, mem_data_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_data, mem_req, mem_addr
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping N-1 -> 0. Shared with the future allocator/GC write arbiter.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] rot;

  always_comb begin
    req_dbl = {req, req};
    rot     = req_dbl >> ptr;
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    // Walk from the far end so the smallest offset from ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        idx = IW'(rr_wrap(int'(ptr), k, N));
      end
    end
    if (any) grant = N'(1) << idx;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port lisp memory among NUM_REQ readers.
// Optional MEM_ARB_TIMEOUT_EN bounds the WAIT state and answers 16'hAAAA on abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          timeout_err,
  output arb_state_t    state_dbg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]  req_ready;
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic [ADDR_W-1:0]   addr_sel;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_any;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IW'(i)) addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    req_ready   = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        // mem_data_ready is deliberately not looked at here.
        if (grant_any) begin
          req_ready = grant;
          owner_d   = grant_idx;
          addr_d    = addr_sel;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        state_d  = ARB_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ARB_WAIT: begin
        if (bus.mem_data_ready) begin
          rsp_data_d  = bus.mem_data_out;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rr_ptr_d    = IW'(rr_wrap(int'(owner_q), 1, NUM_REQ));
          state_d     = ARB_IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Data arriving on the limit cycle wins, handled by the branch above.
        else if (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d    = DATA_W'(ARB_TIMEOUT_DATA);
          rsp_valid_d   = NUM_REQ'(1) << owner_q;
          rr_ptr_d      = IW'(rr_wrap(int'(owner_q), 1, NUM_REQ));
          timeout_err_d = 1'b1;
          state_d       = ARB_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr;
  assign busy          = (state_q != ARB_IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, round-robin scoreboard, directed scenarios.
// Scenario 6 follows whether MEM_ARB_TIMEOUT_EN is defined for the build.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NUM_REQ        = 2;
  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int TIMEOUT_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic       timeout_err;
  arb_state_t state_dbg;

  mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int               mem_delay  = 1;
  bit               mem_silent = 1'b0;
  bit               spur_req   = 1'b0;
  int               mem_cnt    = 0;
  logic [ADDR_W-1:0] mem_pend_addr = '0;

  function automatic logic [DATA_W-1:0] mem_val(logic [ADDR_W-1:0] a);
    return a + 16'h0032;
  endfunction

  always @(posedge clk) begin
    #2;
    bus.mem_data_ready = 1'b0;
    if (rst) begin
      mem_cnt = 0;
    end else begin
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.mem_data_ready = 1'b1;
          bus.mem_data_out   = mem_val(mem_pend_addr);
        end
      end
      if (bus.mem_req && !mem_silent) begin
        mem_cnt       = mem_delay;
        mem_pend_addr = bus.mem_addr;
      end
    end
    if (spur_req) begin
      bus.mem_data_ready = 1'b1;
      bus.mem_data_out   = 16'hDEAD;
      spur_req           = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int                own_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [ADDR_W-1:0] tb_addr [NUM_REQ];
  int                m_ptr = 0;
  int                rsp_count = 0;
  int                rsp_per [NUM_REQ];
  int                grant_log[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); own_q.delete(); addr_q.delete();
      m_ptr = 0;
    end else begin
      int w;
      int own;
      logic [NUM_REQ-1:0] exp_ready;
      logic [DATA_W-1:0]  exp_d;
      if (bus.rsp_valid != '0) begin
        if (own_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          own   = own_q.pop_front();
          exp_d = exp_q.pop_front();
          check_eq("rsp_owner", 32'(bus.rsp_valid), 32'(1) << own);
          check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
          m_ptr = (own + 1) % NUM_REQ;
          rsp_count++;
          rsp_per[own]++;
        end
      end
      if (bus.mem_req) begin
        if (addr_q.size() == 0) check_eq("mem_req_extra", 32'(bus.mem_req), 32'd0);
        else check_eq("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
      end else begin
        check_eq("mem_addr_idle", 32'(bus.mem_addr), 32'd0);
      end
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_ptr + k) % NUM_REQ;
        if (w < 0 && bus.req_valid[j]) w = j;
      end
      exp_ready = '0;
      if (own_q.size() == 0 && w >= 0) exp_ready = NUM_REQ'(1) << w;
      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      if (exp_ready != '0) begin
        own_q.push_back(w);
        exp_q.push_back(mem_silent ? DATA_W'(ARB_TIMEOUT_DATA) : mem_val(tb_addr[w]));
        addr_q.push_back(tb_addr[w]);
        grant_log.push_back(w);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit v, logic [ADDR_W-1:0] a);
    bus.req_valid[i]               = v;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    tb_addr[i]                     = a;
  endtask

  task automatic do_txn(int i, logic [ADDR_W-1:0] a);
    bit got;
    got = 1'b0;
    set_req(i, 1'b1, a);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("txn_ready", 32'(got), 32'd1);
    tick();
    set_req(i, 1'b0, a);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (!busy && own_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic pulse_rst();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int base;
    int lb;
    int n;
    int per0;
    int per1;
    bit seen;
    bus.req_valid      = '0;
    bus.req_addr       = '0;
    bus.mem_data_ready = 1'b0;
    bus.mem_data_out   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tb_addr[i] = '0;
      rsp_per[i] = 0;
    end

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_timeout", 32'(timeout_err), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(ARB_IDLE));
    tick();
    rst = 1'b0;

    // 1: single read, exact latency with single-cycle memory
    tick();
    set_req(0, 1'b1, 16'h0010);
    @(negedge clk);
    check_eq("t1_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 16'h0010);
    @(negedge clk);
    check_eq("t1_mem_req", 32'(bus.mem_req), 32'd1);
    check_eq("t1_mem_addr", 32'(bus.mem_addr), 32'h0010);
    @(negedge clk);
    check_eq("t1_mem_req_once", 32'(bus.mem_req), 32'd0);
    check_eq("t1_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check_eq("t1_rsp_data", 32'(bus.rsp_data), 32'h0042);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // 2: both requesters held -> alternating grants, 4 each in 8
    wait_idle();
    base = rsp_count;
    lb   = grant_log.size();
    per0 = rsp_per[0];
    per1 = rsp_per[1];
    tick();
    set_req(0, 1'b1, 16'h0100);
    set_req(1, 1'b1, 16'h0200);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (rsp_count - base >= 8) break;
    end
    check_eq("t2_count", 32'(rsp_count - base), 32'd8);
    check_eq("t2_req0", 32'(rsp_per[0] - per0), 32'd4);
    check_eq("t2_req1", 32'(rsp_per[1] - per1), 32'd4);
    if (grant_log.size() >= lb + 8) begin
      for (int k = 1; k < 8; k++)
        check_eq("t2_alternate", 32'(grant_log[lb+k]), 32'(1 - grant_log[lb+k-1]));
    end
    tick();
    set_req(0, 1'b0, 16'h0100);
    set_req(1, 1'b0, 16'h0200);
    wait_idle();

    // 3: requester 1 arrives during requester 0's read
    mem_delay = 4;
    tick();
    set_req(0, 1'b1, 16'h0300);
    @(negedge clk);
    check_eq("t3_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 16'h0300);
    set_req(1, 1'b1, 16'h0400);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rsp_valid == '0) begin
        check_eq("t3_held_off", 32'(bus.req_ready), 32'd0);
      end else begin
        check_eq("t3_rsp0", 32'(bus.rsp_valid), 32'h1);
        check_eq("t3_accept1", 32'(bus.req_ready), 32'h2);
        seen = 1'b1;
        break;
      end
    end
    check_eq("t3_rsp_seen", 32'(seen), 32'd1);
    tick();
    set_req(1, 1'b0, 16'h0400);
    wait_idle();

    // 4: reset while in WAIT, then a stray data_ready
    tick();
    set_req(0, 1'b1, 16'h0500);
    @(negedge clk);
    tick();
    set_req(0, 1'b0, 16'h0500);
    tick();
    @(negedge clk);
    check_eq("t4_in_wait", 32'(state_dbg), 32'(ARB_WAIT));
    pulse_rst();
    @(negedge clk);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("t4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    spur_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("t4_late_ignored", 32'(bus.rsp_valid), 32'd0);
    end

    // 5: spurious data_ready in IDLE
    mem_delay = 1;
    tick();
    spur_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check_eq("t5_idle", 32'(state_dbg), 32'(ARB_IDLE));
    end

    // 6: memory never answers
    mem_silent = 1'b1;
    tick();
    set_req(1, 1'b1, 16'h0600);
    @(negedge clk);
    check_eq("t6_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 16'h0600);
    @(negedge clk);
    check_eq("t6_issue", 32'(bus.mem_req), 32'd1);
`ifdef MEM_ARB_TIMEOUT_EN
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid != '0) break;
    end
    check_eq("t6_latency", 32'(n), 32'd9);
    check_eq("t6_rsp_owner", 32'(bus.rsp_valid), 32'h2);
    check_eq("t6_rsp_data", 32'(bus.rsp_data), 32'hAAAA);
    check_eq("t6_err_set", 32'(timeout_err), 32'd1);
    mem_silent = 1'b0;
    wait_idle();
    do_txn(0, 16'h0700);
    wait_idle();
    check_eq("t6_err_sticky", 32'(timeout_err), 32'd1);
    pulse_rst();
    @(negedge clk);
    check_eq("t6_err_cleared", 32'(timeout_err), 32'd0);
`else
    base = rsp_count;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy) n++;
    end
    check_eq("t6_busy_cycles", 32'(n), 32'd300);
    check_eq("t6_no_rsp", 32'(rsp_count - base), 32'd0);
    check_eq("t6_no_err", 32'(timeout_err), 32'd0);
    mem_silent = 1'b0;
    pulse_rst();
    @(negedge clk);
    check_eq("t6_busy_cleared", 32'(busy), 32'd0);
`endif

    // back to normal traffic after the abort
    do_txn(1, 16'h0810);
    wait_idle();
    check_eq("end_own_q", 32'(own_q.size()), 32'd0);
    check_eq("end_addr_q", 32'(addr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
